// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the program-counter sequencer.
//   - Execute-stage opcode constants the sequencer acts on.
//   - funct3 encodings of the conditional branch set.
//   - Sequencer state encoding (enum for debug views, localparams for the FSM).
package pc_pkg;

  // Opcodes decoded by the sequencer
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_HALT   = 7'h7F;

  // Branch funct3 codes (010 and 011 are unused and never taken)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Sequencer states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/pc_sequencer_branch_resolve.sv
// branch_resolve: combinational branch-condition evaluator.
// Ports:
//   opcode  in  7  execute-stage opcode; only OP_BRANCH can produce taken
//   funct3  in  3  branch condition selector
//   cmp_eq  in  1  operands equal
//   cmp_lt  in  1  signed less-than
//   cmp_ltu in  1  unsigned less-than
//   taken   out 1  conditional branch is taken
module branch_resolve
  import pc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       cmp_eq,
  input  logic       cmp_lt,
  input  logic       cmp_ltu,
  output logic       taken
);

  // Evaluate the condition selected by funct3; flags are ignored off-branch
  always_comb begin
    taken = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (funct3)
        F3_BEQ:  taken = cmp_eq;
        F3_BNE:  taken = ~cmp_eq;
        F3_BLT:  taken = cmp_lt;
        F3_BGE:  taken = ~cmp_lt;
        F3_BLTU: taken = cmp_ltu;
        F3_BGEU: taken = ~cmp_ltu;
        default: taken = 1'b0;
      endcase
    end else begin
      taken = 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generator at the head of the fetch stage.
// Resolves branches/JAL/JALR from execute-stage inputs, handles traps,
// stall, halt/resume and inserts flush bubbles after taken redirects.
// Optional feature macro: PC_MISALIGN_TRAP_EN -- a taken redirect to a
// target with bits[1:0] != 0 is turned into a trap and pulses misaligned.
// Ports:
//   clk         in  1      clock, rising edge
//   rst         in  1      synchronous active-high reset
//   stall       in  1      hold PC, ignore decode
//   opcode      in  7      execute-stage opcode
//   funct3      in  3      execute-stage funct3
//   cmp_eq/lt/ltu in 1     comparator flags
//   target      in  WIDTH  jump/branch target
//   trap_req    in  1      redirect to TRAP_VECTOR
//   resume      in  1      leave HALTED
//   pc          out WIDTH  current instruction address (registered)
//   pc_seq      out WIDTH  pc + 4 (combinational)
//   redirect    out 1      taken control transfer this cycle (combinational)
//   fetch_valid out 1      high in RUN
//   halted      out 1      high in HALTED
//   misaligned  out 1      one-cycle pulse on a misaligned redirect
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             cmp_ltu,
  input  logic [WIDTH-1:0] target,
  input  logic             trap_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             redirect,
  output logic             fetch_valid,
  output logic             halted,
  output logic             misaligned
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic       FLUSH_EN   = (FLUSH_CYCLES != 0);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [3:0]       flush_cnt;
  logic [3:0]       flush_cnt_next;
  logic [WIDTH-1:0] pc_next;
  logic             mis_next;
  logic             br_taken;
  logic             taken;
  logic [WIDTH-1:0] jump_target;
  logic             run_taken;
  logic             misalign_hit;

  branch_resolve u_branch_resolve (
    .opcode  (opcode),
    .funct3  (funct3),
    .cmp_eq  (cmp_eq),
    .cmp_lt  (cmp_lt),
    .cmp_ltu (cmp_ltu),
    .taken   (br_taken)
  );

  assign pc_seq      = pc + WIDTH'(32'd4);
  assign fetch_valid = (state == ST_RUN);
  assign halted      = (state == ST_HALTED);

  // Classify the execute-stage instruction and form its final target
  always_comb begin
    taken       = 1'b0;
    jump_target = target;
    case (opcode)
      OP_JAL: begin
        taken       = 1'b1;
        jump_target = target;
      end
      OP_JALR: begin
        taken       = 1'b1;
        jump_target = {target[WIDTH-1:1], 1'b0};
      end
      OP_BRANCH: begin
        taken       = br_taken;
        jump_target = target;
      end
      default: begin
        taken       = 1'b0;
        jump_target = target;
      end
    endcase
  end

  // A decode-driven transfer only counts when running and not stalled
  assign run_taken = ~rst & (state == ST_RUN) & ~stall & taken;
  assign redirect  = ~rst & (trap_req | run_taken);

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_hit = run_taken & (jump_target[1:0] != 2'b00);
`else
  assign misalign_hit = 1'b0;
`endif

  // Next-state logic: trap first, then the per-state action, stall, decode
  always_comb begin
    pc_next        = pc;
    state_next     = state;
    flush_cnt_next = flush_cnt;
    mis_next       = 1'b0;
    if (trap_req) begin
      pc_next = TRAP_VECTOR;
      if (FLUSH_EN) begin
        state_next     = ST_FLUSH;
        flush_cnt_next = FLUSH_INIT;
      end else begin
        state_next     = ST_RUN;
        flush_cnt_next = 4'd0;
      end
    end else begin
      case (state)
        ST_HALTED: begin
          if (resume) begin
            pc_next    = pc_seq;
            state_next = ST_RUN;
          end else begin
            state_next = ST_HALTED;
          end
        end
        ST_FLUSH: begin
          // Count runs regardless of stall; a zero count is treated as expired
          if (flush_cnt <= 4'd1) begin
            flush_cnt_next = 4'd0;
            state_next     = ST_RUN;
          end else begin
            flush_cnt_next = flush_cnt - 4'd1;
            state_next     = ST_FLUSH;
          end
        end
        ST_RUN: begin
          if (stall) begin
            pc_next = pc;
          end else if (opcode == OP_HALT) begin
            state_next = ST_HALTED;
          end else if (taken) begin
            if (misalign_hit) begin
              pc_next  = TRAP_VECTOR;
              mis_next = 1'b1;
            end else begin
              pc_next = jump_target;
            end
            if (FLUSH_EN) begin
              state_next     = ST_FLUSH;
              flush_cnt_next = FLUSH_INIT;
            end else begin
              state_next     = ST_RUN;
              flush_cnt_next = 4'd0;
            end
          end else begin
            pc_next = pc_seq;
          end
        end
        default: begin
          state_next     = ST_RUN;
          flush_cnt_next = 4'd0;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_VECTOR;
      state     <= ST_RUN;
      flush_cnt <= 4'd0;
      misaligned <= 1'b0;
    end else begin
      pc        <= pc_next;
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      misaligned <= mis_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Main instance: WIDTH=32, RESET_VECTOR=0x40, TRAP_VECTOR=0x100, FLUSH_CYCLES=2.
// Small instance: WIDTH=8, RESET_VECTOR=0xF8, TRAP_VECTOR=0x80, FLUSH_CYCLES=0.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, cmp_eq, cmp_lt, cmp_ltu, trap_req, resume;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] target;
  logic [31:0] pc, pc_seq;
  logic        redirect, fetch_valid, halted, misaligned;

  logic        s_rst, s_stall, s_trap_req, s_resume;
  logic [6:0]  s_opcode;
  logic [7:0]  s_target;
  logic [7:0]  s_pc, s_pc_seq;
  logic        s_redirect, s_fetch_valid, s_halted, s_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH(32), .RESET_VECTOR(32'h0000_0040), .TRAP_VECTOR(32'h0000_0100), .FLUSH_CYCLES(2)
  ) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode), .funct3(funct3),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu), .target(target),
    .trap_req(trap_req), .resume(resume), .pc(pc), .pc_seq(pc_seq),
    .redirect(redirect), .fetch_valid(fetch_valid), .halted(halted),
    .misaligned(misaligned)
  );

  pc_sequencer #(
    .WIDTH(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h80), .FLUSH_CYCLES(0)
  ) u_small (
    .clk(clk), .rst(s_rst), .stall(s_stall), .opcode(s_opcode), .funct3(3'b000),
    .cmp_eq(1'b0), .cmp_lt(1'b0), .cmp_ltu(1'b0), .target(s_target),
    .trap_req(s_trap_req), .resume(s_resume), .pc(s_pc), .pc_seq(s_pc_seq),
    .redirect(s_redirect), .fetch_valid(s_fetch_valid), .halted(s_halted),
    .misaligned(s_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; opcode = 7'h6F; funct3 = 3'b000;
    cmp_eq = 1'b0; cmp_lt = 1'b0; cmp_ltu = 1'b0; target = 32'h0000_0999;
    trap_req = 1'b0; resume = 1'b0;
    s_rst = 1'b1; s_stall = 1'b1; s_trap_req = 1'b0; s_resume = 1'b0;
    s_opcode = 7'h13; s_target = 8'h00;
    step(); step();
    // reset state; JAL on the bus must not redirect while in reset
    chk("rst_pc", pc, 32'h40);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);

    rst = 1'b0; opcode = 7'h13; #1;
    chk("run_fv", {31'd0, fetch_valid}, 32'd1);
    chk("run_halted", {31'd0, halted}, 32'd0);
    chk("run_pc_seq", pc_seq, 32'h44);
    step(); chk("seq1", pc, 32'h44);
    step(); chk("seq2", pc, 32'h48);
    step(); chk("seq3", pc, 32'h4C);
    chk("seq_fv", {31'd0, fetch_valid}, 32'd1);

    // BLT taken -> 2 bubble cycles
    opcode = 7'h63; funct3 = 3'b100; cmp_lt = 1'b1; target = 32'h200; #1;
    chk("blt_redirect", {31'd0, redirect}, 32'd1);
    step(); chk("blt_pc", pc, 32'h200);
    chk("blt_fv0", {31'd0, fetch_valid}, 32'd0);
    opcode = 7'h6F; target = 32'h500; cmp_lt = 1'b0; #1;
    chk("flush_no_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("flush_pc", pc, 32'h200);
    chk("blt_fv1", {31'd0, fetch_valid}, 32'd0);
    opcode = 7'h13; step();
    chk("blt_fv_back", {31'd0, fetch_valid}, 32'd1);
    chk("blt_pc_hold", pc, 32'h200);

    // BGEU with ltu=1 not taken
    opcode = 7'h63; funct3 = 3'b111; cmp_ltu = 1'b1; #1;
    chk("bgeu_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("bgeu_pc", pc, 32'h204);
    // flags ignored for non-branch opcode
    opcode = 7'h33; funct3 = 3'b000; cmp_eq = 1'b1; cmp_ltu = 1'b0; #1;
    chk("nonbr_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("nonbr_pc", pc, 32'h208);
    // BEQ not taken, then BNE taken (cmp_eq=0)
    opcode = 7'h63; funct3 = 3'b000; cmp_eq = 1'b0; #1;
    chk("beq_nt_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("beq_nt_pc", pc, 32'h20C);
    funct3 = 3'b001; target = 32'h280; #1;
    chk("bne_redirect", {31'd0, redirect}, 32'd1);
    step(); chk("bne_pc", pc, 32'h280);
    opcode = 7'h13; step(); step();

    // JALR clears bit 0
    opcode = 7'h67; target = 32'h301; #1;
    chk("jalr_redirect", {31'd0, redirect}, 32'd1);
    step(); chk("jalr_pc", pc, 32'h300);
    opcode = 7'h13; step(); step();

    // JAL to a misaligned target
    opcode = 7'h6F; target = 32'h302;
    step();
`ifdef PC_MISALIGN_TRAP_EN
    chk("jal_mis_pc", pc, 32'h100);
    chk("jal_mis_pulse", {31'd0, misaligned}, 32'd1);
`else
    chk("jal_mis_pc", pc, 32'h302);
    chk("jal_mis_pulse", {31'd0, misaligned}, 32'd0);
`endif
    opcode = 7'h13; step();
    chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
    step();

    // JAL to 0x10, then halt
    opcode = 7'h6F; target = 32'h10; step();
    opcode = 7'h13; step(); step();
    chk("pre_halt_pc", pc, 32'h10);
    opcode = 7'h7F; #1;
    chk("halt_redirect", {31'd0, redirect}, 32'd0);
    step();
    chk("halted1", {31'd0, halted}, 32'd1);
    chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
    opcode = 7'h6F; target = 32'h900; stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("halted5", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc, 32'h10);
    opcode = 7'h13; resume = 1'b1; step();
    resume = 1'b0;
    chk("resume_pc", pc, 32'h14);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_fv", {31'd0, fetch_valid}, 32'd1);

    // stall blocks JAL; trap overrides stall
    opcode = 7'h6F; target = 32'h700; #1;
    chk("stall_redirect", {31'd0, redirect}, 32'd0);
    step(); chk("stall_pc", pc, 32'h14);
    trap_req = 1'b1; #1;
    chk("trap_redirect", {31'd0, redirect}, 32'd1);
    step(); chk("trap_pc", pc, 32'h100);
    trap_req = 1'b0; opcode = 7'h13;
    step(); chk("trap_fv1", {31'd0, fetch_valid}, 32'd0);
    step(); chk("stall_no_freeze_fv", {31'd0, fetch_valid}, 32'd1);
    chk("stall_hold_pc", pc, 32'h100);
    stall = 1'b0; step(); chk("post_stall_pc", pc, 32'h104);

    // trap during FLUSH restarts the count
    opcode = 7'h6F; target = 32'h400; step();
    opcode = 7'h13; step();
    trap_req = 1'b1; step(); trap_req = 1'b0;
    chk("retrap_pc", pc, 32'h100);
    step(); chk("retrap_fv", {31'd0, fetch_valid}, 32'd0);
    step(); chk("retrap_fv_back", {31'd0, fetch_valid}, 32'd1);

    // reset during FLUSH
    opcode = 7'h6F; target = 32'h600; step();
    opcode = 7'h13; rst = 1'b1; step();
    chk("rst_flush_pc", pc, 32'h40);
    chk("rst_flush_fv", {31'd0, fetch_valid}, 32'd1);
    rst = 1'b0; step(); chk("rst_flush_seq", pc, 32'h44);

    // 8-bit instance: wrap and zero-cycle flush
    stall = 1'b1;
    s_rst = 1'b0; s_stall = 1'b0; #1;
    chk("s_rst_pc", {24'd0, s_pc}, 32'hF8);
    step(); chk("s_pc_fc", {24'd0, s_pc}, 32'hFC);
    chk("s_pc_seq_wrap", {24'd0, s_pc_seq}, 32'h00);
    step(); chk("s_pc_wrap", {24'd0, s_pc}, 32'h00);
    s_opcode = 7'h6F; s_target = 8'h20; #1;
    chk("s_jal_redirect", {31'd0, s_redirect}, 32'd1);
    step(); chk("s_jal_pc", {24'd0, s_pc}, 32'h20);
    chk("s_noflush_fv", {31'd0, s_fetch_valid}, 32'd1);
    s_opcode = 7'h13; s_trap_req = 1'b1; step(); s_trap_req = 1'b0;
    chk("s_trap_pc", {24'd0, s_pc}, 32'h80);
    chk("s_trap_fv", {31'd0, s_fetch_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
